s3ga_wb_master: RTL and testbench
=================================

Name: s3ga_wb_master

Overview:
Wishbone classic single-transfer initiator: the master end of the Wishbone slave port exposed by s3ga_proj. It accepts register read/write commands on a valid/ready stream and drives single pipelined-free Wishbone cycles (one outstanding). It returns read data or a timeout indication on a response stream. It is used by the on-chip configuration loader and by the harness to program and read back the fabric over the same bus the management SoC uses.

Parameters:
TIMEOUT, 255, number of cycles with stb high and no ack before the transfer is abandoned (1..2^TO_W-1)
TO_W, 8, width of the per-transfer wait timer
ERR_DATA, 32'hFFFF_FFFF, value returned on rsp_dat_o when a transfer times out

Ports:
wb_clk_i  in  1  bus clock; all logic on the rising edge
wb_rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command offered
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write, 0=read
cmd_adr_i  in  32  byte address
cmd_dat_i  in  32  write data
cmd_sel_i  in  4  byte lane selects
rsp_valid_o  out  1  response available
rsp_ready_i  in  1  response consumed when valid&ready
rsp_dat_o  out  32  read data (0 for writes, ERR_DATA on timeout)
rsp_timeout_o  out  1  transfer abandoned without ack
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  Wishbone write enable
wbm_adr_o  out  32  Wishbone address
wbm_dat_o  out  32  Wishbone write data
wbm_sel_o  out  4  Wishbone byte selects
wbm_ack_i  in  1  Wishbone acknowledge
wbm_dat_i  in  32  Wishbone read data
timeouts_o  out  8  saturating count of timed-out transfers since reset

Behaviour:
- One clock (wb_clk_i); reset asynchronous, active-low (wb_rst_ni). Reset forces state IDLE. All registered outputs reset to 0: cyc, stb, we, adr, dat, sel, rsp_valid, rsp_dat, rsp_timeout, timeouts. The timer also resets to 0.
- FSM states: IDLE, BUS, RESP.
- cmd_ready_o = (state==IDLE), decoded from the state register. It has no combinational path from cmd_valid_i.
- IDLE, on cmd_valid_i:
  - Register we/adr/dat/sel onto the wbm_* outputs.
  - Set cyc=stb=1 from the next cycle.
  - Clear the timer and go to BUS.
- BUS:
  - cyc, stb, we, adr, dat and sel are held stable.
  - The timer increments each cycle ack is low.
- BUS, wbm_ack_i=1 sampled:
  - Next cycle: cyc=stb=0 and rsp_valid=1.
  - rsp_dat = wbm_dat_i for a read, 0 for a write.
  - rsp_timeout=0. Go to RESP.
- BUS, timer==TIMEOUT and ack=0:
  - Next cycle: cyc=stb=0, rsp_valid=1, rsp_dat=ERR_DATA, rsp_timeout=1.
  - timeouts saturates at 255. Go to RESP.
- Ack and timer==TIMEOUT in the same cycle: ack wins and no timeout is recorded.
- A zero-wait slave is legal: ack in the first stb cycle.
- Latency: command accepted at edge 0 → stb high in cycle 1 → ack sampled at edge k (k≥1) → rsp_valid high from edge k+1. Minimum is 2 cycles from accept to response.
- RESP:
  - rsp_valid, rsp_dat and rsp_timeout are held until rsp_ready_i.
  - On handshake, clear rsp_valid and rsp_timeout and go to IDLE.
  - One idle bubble occurs before the next command is accepted.
- wbm_ack_i outside BUS is ignored; no state change and no counter change.
- wbm_dat_o, wbm_adr_o and wbm_sel_o are don't-care outside BUS. They keep their last value to limit toggling.
- Reset asserted mid-transfer drops cyc/stb immediately (asynchronously). It does not produce a response. The team accepts that a slave may see a truncated cycle.

Decomposition:
- Package s3ga_wb_pkg holds:
  - WB_AW=32, WB_DW=32, WB_SW=4
  - state enum wbm_state_t {IDLE, BUS, RESP}
  - ERR_DATA default constant
- The package is shared with s3ga_proj's slave logic.
- The block is a single module; no sub-module is needed, because the timer and FSM are about 150 lines.

Test Plan:
- Write adr=0x3000_0010, dat=0xA5A5_1234, sel=0xF; slave acks 2 cycles after stb → bus shows exactly those values, cyc held 2 cycles; then rsp_valid=1, rsp_dat=0, rsp_timeout=0.
- Read adr=0x3000_0004; zero-wait slave returns 0xCAFE_F00D → response 2 cycles after accept with rsp_dat=0xCAFE_F00D.
- TIMEOUT=4, slave never acks → stb high exactly 5 cycles; rsp_timeout=1, rsp_dat=0xFFFF_FFFF, timeouts increments to 1. Repeat 300 times → timeouts=255.
- Ack arrives in the same cycle the timer hits TIMEOUT → normal response with rsp_timeout=0; timeouts unchanged.
- Hold rsp_ready_i=0 for 10 cycles while cmd_valid_i=1 → rsp fields stable, cmd_ready_o=0, cyc=0. Release → next command is accepted one cycle after the handshake.
- Deassert wb_rst_ni during BUS → cyc/stb/rsp_valid read 0 in the same cycle. After release, a read completes normally; a stray ack during IDLE is ignored.

Source files
------------

// File: rtl/s3ga_wb_pkg.sv
// ----------------------------------------------------------------------------
// s3ga_wb_pkg
// Shared Wishbone definitions for the s3ga_proj register bus. Both the
// initiator (s3ga_wb_master) and the fabric-side slave logic import this.
//   WB_AW / WB_DW / WB_SW : address, data and byte-select widths
//   ERR_DATA_DEFAULT      : read-data pattern returned for abandoned transfers
//   wbm_state_t           : initiator FSM states
//   satInc8               : saturating 8-bit increment for event counters
// ----------------------------------------------------------------------------
package s3ga_wb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    localparam logic [WB_DW-1:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_t;

    // Event counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [7:0] satInc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/s3ga_wb_master_if.sv
// ----------------------------------------------------------------------------
// s3ga_wb_master_if
// Wishbone classic bus between the configuration initiator and the
// s3ga_proj slave port. Signal directions are named from the master side.
//   wbm_cyc_o / wbm_stb_o : cycle and strobe
//   wbm_we_o              : write enable
//   wbm_adr_o             : byte address
//   wbm_dat_o / wbm_sel_o : write data and byte lane selects
//   wbm_ack_i / wbm_dat_i : acknowledge and read data from the slave
// ----------------------------------------------------------------------------
interface s3ga_wb_master_if;
    import s3ga_wb_pkg::*;

    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [WB_AW-1:0] wbm_adr_o;
    logic [WB_DW-1:0] wbm_dat_o;
    logic [WB_SW-1:0] wbm_sel_o;
    logic             wbm_ack_i;
    logic [WB_DW-1:0] wbm_dat_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        output wbm_ack_i, wbm_dat_i
    );

endinterface

// File: rtl/s3ga_wb_master.sv
// ----------------------------------------------------------------------------
// s3ga_wb_master
// Single-outstanding Wishbone classic initiator. Register commands arrive on
// a valid/ready stream, each becomes one bus cycle, and the outcome (read
// data, zero for writes, or ERR_DATA on timeout) leaves on a response stream.
//   wb_clk_i, wb_rst_ni        : clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o  : command handshake
//   cmd_we_i/adr_i/dat_i/sel_i : command fields
//   rsp_valid_o / rsp_ready_i  : response handshake
//   rsp_dat_o, rsp_timeout_o   : response fields
//   wbm                        : Wishbone bus (master modport)
//   timeouts_o                 : saturating count of abandoned transfers
// ----------------------------------------------------------------------------
module s3ga_wb_master
    import s3ga_wb_pkg::*;
#(
    parameter int               TIMEOUT  = 255,
    parameter int               TO_W     = 8,
    parameter logic [WB_DW-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,

    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [WB_AW-1:0] cmd_adr_i,
    input  logic [WB_DW-1:0] cmd_dat_i,
    input  logic [WB_SW-1:0] cmd_sel_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WB_DW-1:0] rsp_dat_o,
    output logic             rsp_timeout_o,

    s3ga_wb_master_if.master wbm,

    output logic [7:0]       timeouts_o
);

    wbm_state_t       r_state;
    logic [TO_W-1:0]  r_timer;
    logic             r_cyc;
    logic             r_stb;
    logic             r_we;
    logic [WB_AW-1:0] r_adr;
    logic [WB_DW-1:0] r_dat;
    logic [WB_SW-1:0] r_sel;
    logic             r_rspValid;
    logic [WB_DW-1:0] r_rspDat;
    logic             r_rspTimeout;
    logic [7:0]       r_timeouts;

    // Whole transfer sequencer. IDLE latches a command onto the bus, BUS waits
    // for ack or for the wait timer to expire (ack takes priority when both
    // happen in the same cycle), RESP holds the result until it is consumed.
    // The bus address/data/select registers are only loaded on acceptance so
    // they stay quiet between transfers. Reset drops cyc/stb asynchronously,
    // so a slave can observe a truncated cycle, and no response is produced.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_sel        <= '0;
            r_rspValid   <= 1'b0;
            r_rspDat     <= '0;
            r_rspTimeout <= 1'b0;
            r_timeouts   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        r_we    <= cmd_we_i;
                        r_adr   <= cmd_adr_i;
                        r_dat   <= cmd_dat_i;
                        r_sel   <= cmd_sel_i;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_timer <= '0;
                        r_state <= BUS;
                    end
                end
                BUS: begin
                    if (wbm.wbm_ack_i) begin
                        r_cyc        <= 1'b0;
                        r_stb        <= 1'b0;
                        r_rspValid   <= 1'b1;
                        r_rspDat     <= r_we ? '0 : wbm.wbm_dat_i;
                        r_rspTimeout <= 1'b0;
                        r_state      <= RESP;
                    end else if (r_timer == TO_W'(TIMEOUT)) begin
                        r_cyc        <= 1'b0;
                        r_stb        <= 1'b0;
                        r_rspValid   <= 1'b1;
                        r_rspDat     <= ERR_DATA;
                        r_rspTimeout <= 1'b1;
                        r_timeouts   <= satInc8(r_timeouts);
                        r_state      <= RESP;
                    end else begin
                        r_timer <= r_timer + TO_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rspValid   <= 1'b0;
                        r_rspTimeout <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Ready is a pure decode of the state register, so the command stream has
    // no combinational path from valid to ready.
    assign cmd_ready_o   = (r_state == IDLE);

    assign rsp_valid_o   = r_rspValid;
    assign rsp_dat_o     = r_rspDat;
    assign rsp_timeout_o = r_rspTimeout;
    assign timeouts_o    = r_timeouts;

    assign wbm.wbm_cyc_o = r_cyc;
    assign wbm.wbm_stb_o = r_stb;
    assign wbm.wbm_we_o  = r_we;
    assign wbm.wbm_adr_o = r_adr;
    assign wbm.wbm_dat_o = r_dat;
    assign wbm.wbm_sel_o = r_sel;

endmodule

// File: tb/tb_s3ga_wb_master.sv
// ----------------------------------------------------------------------------
// tb_s3ga_wb_master
// Self-checking bench for s3ga_wb_master with TIMEOUT=4. A table of command
// records is driven through the initiator while the bench plays a Wishbone
// slave with a programmable number of wait states; expected responses are
// queued when a command is issued and popped when the response appears.
// Hand-written sequences cover back-pressure, counter saturation and reset
// in the middle of a bus cycle.
// ----------------------------------------------------------------------------
module tb_s3ga_wb_master;
    import s3ga_wb_pkg::*;

    localparam int TB_TIMEOUT = 4;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          waits;
        logic [31:0] rdData;
        logic [31:0] expDat;
        logic        expTimeout;
        int          expStb;
    } vec_t;

    typedef struct packed {
        logic [31:0] dat;
        logic        timeout;
    } rsp_t;

    logic        clk;
    logic        rstN;
    logic        cmdValid;
    logic        cmdReady;
    logic        cmdWe;
    logic [31:0] cmdAdr;
    logic [31:0] cmdDat;
    logic [3:0]  cmdSel;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspDat;
    logic        rspTimeout;
    logic [7:0]  timeouts;

    s3ga_wb_master_if wbIf();

    s3ga_wb_master #(
        .TIMEOUT (TB_TIMEOUT),
        .TO_W    (8),
        .ERR_DATA(32'hFFFF_FFFF)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rstN),
        .cmd_valid_i  (cmdValid),
        .cmd_ready_o  (cmdReady),
        .cmd_we_i     (cmdWe),
        .cmd_adr_i    (cmdAdr),
        .cmd_dat_i    (cmdDat),
        .cmd_sel_i    (cmdSel),
        .rsp_valid_o  (rspValid),
        .rsp_ready_i  (rspReady),
        .rsp_dat_o    (rspDat),
        .rsp_timeout_o(rspTimeout),
        .wbm          (wbIf),
        .timeouts_o   (timeouts)
    );

    int   checks = 0;
    int   errors = 0;
    int   expTimeouts = 0;
    rsp_t expQ[$];
    vec_t vecs[6];

    // Free-running 100 MHz bus clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backstop so a wedged run still ends with a diagnostic.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got simulation time %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                   input logic [3:0] sel, input int waits, input logic [31:0] rdData,
                                   input logic [31:0] expDat, input logic expTimeout, input int expStb);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.waits = waits;
        v.rdData = rdData; v.expDat = expDat; v.expTimeout = expTimeout; v.expStb = expStb;
        return v;
    endfunction

    // Waits (bounded) for the initiator to be ready and presents one command;
    // returns just after the accepting rising edge.
    task automatic issueCommand(input vec_t v);
        bit ready = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmdReady) begin
                ready = 1;
                break;
            end
        end
        checkVal("cmdReadyWait", 32'(ready), 32'd1);
        cmdValid = 1'b1;
        cmdWe    = v.we;
        cmdAdr   = v.adr;
        cmdDat   = v.dat;
        cmdSel   = v.sel;
        @(posedge clk);
    endtask

    // Plays the slave after a command was accepted: acks after v.waits strobe
    // cycles (negative = never), checks the bus fields, strobe length and
    // accept-to-response latency, and queues the expected response.
    task automatic applyStimulus(input vec_t v);
        int stbCnt = 0;
        int lat = 0;
        bit busBad = 0;
        bit done = 0;
        expQ.push_back('{dat: v.expDat, timeout: v.expTimeout});
        for (int i = 1; i <= 60 && !done; i++) begin
            @(negedge clk);
            cmdValid = 1'b0;
            if (rspValid) begin
                done = 1;
                lat  = i;
                wbIf.wbm_ack_i = 1'b0;
            end else if (wbIf.wbm_cyc_o && wbIf.wbm_stb_o) begin
                if (wbIf.wbm_we_o !== v.we || wbIf.wbm_adr_o !== v.adr ||
                    wbIf.wbm_dat_o !== v.dat || wbIf.wbm_sel_o !== v.sel)
                    busBad = 1;
                stbCnt++;
                if (v.waits >= 0 && stbCnt - 1 == v.waits) begin
                    wbIf.wbm_ack_i = 1'b1;
                    wbIf.wbm_dat_i = v.rdData;
                end else begin
                    wbIf.wbm_ack_i = 1'b0;
                    wbIf.wbm_dat_i = 32'hDEAD_BEEF;
                end
            end else begin
                wbIf.wbm_ack_i = 1'b0;
            end
        end
        checkVal("rspArrived", 32'(done), 32'd1);
        checkVal("busFieldsBad", 32'(busBad), 32'd0);
        checkVal("stbCycles", 32'(stbCnt), 32'(v.expStb));
        checkVal("latency", 32'(lat), 32'(v.expStb + 1));
    endtask

    // Pops the scoreboard, compares the held response, then handshakes it.
    task automatic checkOutput();
        rsp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboardEmpty: got 0 entries, expected 1");
        end else begin
            e = expQ.pop_front();
            if (e.timeout && expTimeouts < 255) expTimeouts++;
            checkVal("rspValid", 32'(rspValid), 32'd1);
            checkVal("rspDat", rspDat, e.dat);
            checkVal("rspTimeout", 32'(rspTimeout), 32'(e.timeout));
            checkVal("timeouts", 32'(timeouts), 32'(expTimeouts));
        end
        rspReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rspReady = 1'b0;
        checkVal("rspValidCleared", 32'(rspValid), 32'd0);
        checkVal("rspTimeoutCleared", 32'(rspTimeout), 32'd0);
    endtask

    initial begin
        vec_t vBp;
        vec_t vNever;
        vec_t vRd;

        vecs[0] = mkVec(1'b1, 32'h3000_0010, 32'hA5A5_1234, 4'hF,  1, 32'h5555_AAAA, 32'h0000_0000, 1'b0, 2);
        vecs[1] = mkVec(1'b0, 32'h3000_0004, 32'h0000_0000, 4'hF,  0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1);
        vecs[2] = mkVec(1'b0, 32'h3000_0008, 32'h0000_0000, 4'hF, -1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 5);
        vecs[3] = mkVec(1'b0, 32'h3000_000C, 32'h0000_0000, 4'hF,  4, 32'h1234_5678, 32'h1234_5678, 1'b0, 5);
        vecs[4] = mkVec(1'b1, 32'h3000_0014, 32'h0BAD_F00D, 4'h3,  3, 32'h7777_7777, 32'h0000_0000, 1'b0, 4);
        vecs[5] = mkVec(1'b0, 32'h3000_0018, 32'h0000_0000, 4'hC,  2, 32'h8765_4321, 32'h8765_4321, 1'b0, 3);

        rstN = 1'b0; cmdValid = 1'b0; cmdWe = 1'b0; cmdAdr = '0; cmdDat = '0; cmdSel = '0;
        rspReady = 1'b0; wbIf.wbm_ack_i = 1'b0; wbIf.wbm_dat_i = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        checkVal("rstCmdReady", 32'(cmdReady), 32'd1);
        checkVal("rstCyc", 32'(wbIf.wbm_cyc_o), 32'd0);
        checkVal("rstStb", 32'(wbIf.wbm_stb_o), 32'd0);
        checkVal("rstWe", 32'(wbIf.wbm_we_o), 32'd0);
        checkVal("rstAdr", wbIf.wbm_adr_o, 32'd0);
        checkVal("rstDat", wbIf.wbm_dat_o, 32'd0);
        checkVal("rstSel", 32'(wbIf.wbm_sel_o), 32'd0);
        checkVal("rstRspValid", 32'(rspValid), 32'd0);
        checkVal("rstRspDat", rspDat, 32'd0);
        checkVal("rstRspTimeout", 32'(rspTimeout), 32'd0);
        checkVal("rstTimeouts", 32'(timeouts), 32'd0);
        rstN = 1'b1;

        // Table of single transfers.
        for (int i = 0; i < 6; i++) begin
            issueCommand(vecs[i]);
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Back-pressure: response held while a new command waits.
        issueCommand(vecs[5]);
        applyStimulus(vecs[5]);
        vBp = mkVec(1'b1, 32'h3000_0020, 32'h1111_2222, 4'hC, 0, 32'h9999_9999, 32'h0000_0000, 1'b0, 1);
        cmdValid = 1'b1; cmdWe = vBp.we; cmdAdr = vBp.adr; cmdDat = vBp.dat; cmdSel = vBp.sel;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkVal("bpRspValid", 32'(rspValid), 32'd1);
            checkVal("bpRspDat", rspDat, 32'h8765_4321);
            checkVal("bpCmdReady", 32'(cmdReady), 32'd0);
            checkVal("bpCyc", 32'(wbIf.wbm_cyc_o), 32'd0);
        end
        checkOutput();
        checkVal("bpReadyAfterHs", 32'(cmdReady), 32'd1);
        @(posedge clk);
        applyStimulus(vBp);
        checkOutput();

        // Repeated timeouts drive the counter into saturation.
        for (int i = 0; i < 300; i++) begin
            issueCommand(vecs[2]);
            applyStimulus(vecs[2]);
            checkOutput();
        end
        checkVal("timeoutsSaturated", 32'(timeouts), 32'd255);

        // Reset in the middle of a bus cycle.
        vNever = mkVec(1'b0, 32'h3000_0030, 32'h0, 4'hF, -1, 32'h0, 32'hFFFF_FFFF, 1'b1, 5);
        issueCommand(vNever);
        @(negedge clk);
        cmdValid = 1'b0;
        @(negedge clk);
        checkVal("midBusCyc", 32'(wbIf.wbm_cyc_o), 32'd1);
        rstN = 1'b0;
        #1;
        checkVal("asyncRstCyc", 32'(wbIf.wbm_cyc_o), 32'd0);
        checkVal("asyncRstStb", 32'(wbIf.wbm_stb_o), 32'd0);
        checkVal("asyncRstRspValid", 32'(rspValid), 32'd0);
        expTimeouts = 0;
        @(negedge clk);
        rstN = 1'b1;
        checkVal("postRstTimeouts", 32'(timeouts), 32'd0);

        // Stray ack while idle must be ignored.
        wbIf.wbm_ack_i = 1'b1;
        wbIf.wbm_dat_i = 32'h4444_4444;
        repeat (3) @(negedge clk);
        checkVal("strayAckReady", 32'(cmdReady), 32'd1);
        checkVal("strayAckRspValid", 32'(rspValid), 32'd0);
        checkVal("strayAckCyc", 32'(wbIf.wbm_cyc_o), 32'd0);
        checkVal("strayAckTimeouts", 32'(timeouts), 32'd0);
        wbIf.wbm_ack_i = 1'b0;

        vRd = mkVec(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1, 32'h0F0F_A5A5, 32'h0F0F_A5A5, 1'b0, 2);
        issueCommand(vRd);
        applyStimulus(vRd);
        checkOutput();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
